// File: rtl/sram_like_slave_if.sv
// Bus bundle between an SRAM-like initiator and sram_like_slave.
// The request side is driven by the master; the addr_ok/data_ok handshake and
// the response come back from the slave.
interface sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/sram_like_slave.sv
// sram_like_slave: 2^ADDR_W x 32-bit memory behind an SRAM-like handshake.
// One transaction is outstanding at a time. A request is accepted while idle;
// the response strobe data_ok appears LATENCY cycles after the accept edge.
// Read data is sampled on entry to the response state; write bytes commit on
// the edge that leaves it. Misaligned or illegal sizes respond with err and
// never touch memory.
module sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    sram_like_slave_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;

    // Latched request and the view of it used during the current cycle.
    logic              wr_q,    wr_d;
    logic [1:0]        size_q,  size_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W+1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              data_ok_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              req_err;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] idx_q;
    logic              unused_addr_hi;

    // Address bits above the word index wrap onto the same storage.
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    // Idle is the only state that can take a request; reset blocks it.
    assign bus.addr_ok = (state_q == S_IDLE) & ~reset;
    assign accept      = bus.req & bus.addr_ok;

    // Response entry happens at the accept edge itself when LATENCY is 1,
    // otherwise when the WAIT countdown reaches its last cycle.
    assign enter_resp = ((state_q == S_IDLE) & accept & (LATENCY == 1))
                      | ((state_q == S_WAIT) & (cnt_q == 4'd1));

    // Live inputs at the accept edge, the latched copy at every other edge.
    always_comb begin
        // NOTE: every signal written here is assigned on every path; a path that skips one would infer a latch.
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            wr_d    = bus.wr;
            size_d  = bus.size;
            wstrb_d = bus.wstrb;
            addr_d  = bus.addr[ADDR_W+1:0];
            wdata_d = bus.wdata;
        end
    end

    assign idx_d   = addr_d[ADDR_W+1:2];
    assign idx_q   = addr_q[ADDR_W+1:2];
    assign req_err = (size_d == 2'd3)
                   | ((size_d == 2'd1) & addr_d[0])
                   | ((size_d == 2'd2) & (addr_d[1:0] != 2'b00));

    // Control FSM: latches the request, counts latency, registers the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample pre-edge values, whatever the statement order.
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_ok_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // rdata and err only change on response entry and otherwise hold.
            if (enter_resp) begin
                data_ok_q <= 1'b1;
                err_q     <= req_err;
                rdata_q   <= (wr_d | req_err) ? 32'h0 : mem[idx_d];
            end
        end
    end

    // Commit write bytes on the edge leaving RESP; erroring or reset-aborted writes never land.
    always_ff @(posedge clk) begin
        // NOTE: the array is intentionally not reset; its contents survive reset and it can map onto plain RAM.
        if (!reset && (state_q == S_RESP) && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_ok = data_ok_q & ~reset;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning word-index bits; memory depth is 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from the accept edge to data_ok; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning reset: synchronous, active-high.
REQ-005 The block SHALL have port req, input, 1 bit, meaning initiator request valid.
REQ-006 The block SHALL have port wr, input, 1 bit, meaning 1 = write, 0 = read.
REQ-007 The block SHALL have port size, input, 2 bits, meaning 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 The block SHALL have port wstrb, input, 4 bits, meaning byte write enables; ignored on reads.
REQ-009 The block SHALL have port addr, input, 32 bits, meaning byte address; word index is addr[ADDR_W+1:2] and higher bits are ignored.
REQ-010 The block SHALL have port wdata, input, 32 bits, meaning write data.
REQ-011 The block SHALL have port addr_ok, output, 1 bit, meaning request accepted this cycle when req is also high.
REQ-012 The block SHALL have port data_ok, output, 1 bit, meaning single-cycle response strobe.
REQ-013 The block SHALL have port rdata, output, 32 bits, meaning read data, valid while data_ok.
REQ-014 The block SHALL have port err, output, 1 bit, meaning response error, valid while data_ok.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP, allowing one outstanding transaction.
REQ-016 addr_ok SHALL be combinational: (state == IDLE) & ~reset; it SHALL NOT depend on req.
REQ-017 Accept SHALL occur at a rising edge where req & addr_ok; at that edge the block SHALL latch wr, size, wstrb, addr and wdata, and load cnt <= LATENCY-1.
REQ-018 On accept the FSM SHALL go IDLE -> RESP if LATENCY == 1, otherwise IDLE -> WAIT.
REQ-019 In WAIT, cnt SHALL decrement each cycle; when cnt == 1 the FSM SHALL go WAIT -> RESP.
REQ-020 In RESP, data_ok SHALL be 1 for exactly one cycle; the FSM SHALL then return RESP -> IDLE. A new accept is therefore possible at the earliest one cycle after data_ok.
REQ-021 data_ok SHALL be visible exactly LATENCY cycles after the accept edge.
REQ-022 The error condition SHALL be: size == 3, or (size == 1 & addr[0]), or (size == 2 & addr[1:0] != 0). It SHALL be evaluated on the latched request.
REQ-023 On a read, rdata SHALL be registered on entry to RESP as mem[index], the full word regardless of size; on error, rdata SHALL be 0.
REQ-024 On a write, for each i with wstrb[i] set, mem[index] byte i SHALL be written at the edge that exits RESP; rdata SHALL be 0 during a write response.
REQ-025 A write response with err = 1 SHALL leave memory unchanged.
REQ-026 rdata and err SHALL hold their last value outside RESP.
REQ-027 A read accepted after a write's data_ok SHALL return the written data; there is no forwarding requirement inside one transaction.
REQ-028 While the FSM is busy, changes on req, addr, wdata, wstrb, size and wr SHALL have no effect.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE and cnt SHALL clear to 0; data_ok, err and rdata SHALL be 0 from the next cycle; addr_ok SHALL be 0 while reset is high.
REQ-030 Reset asserted during WAIT or RESP SHALL discard the transaction: no memory write and no data_ok.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 Bench SHALL cover: LATENCY=2, write word 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then read 0x10 -> data_ok 2 cycles after each accept, read rdata = 0xDEADBEEF, err = 0.
REQ-033 Bench SHALL cover: mem[4] = 0x11223344, write wdata = 0xAABBCCDD with wstrb = 4'b0101 to addr 0x10, then read -> rdata = 0x11BB33DD.
REQ-034 Bench SHALL cover: read with size = 2, addr = 0x12 -> data_ok with err = 1, rdata = 0; write with size = 1, addr = 0x13 -> err = 1 and memory unchanged.
REQ-035 Bench SHALL cover: req held high continuously with LATENCY = 1 -> addr_ok high every other cycle, data_ok one cycle after each accept, never two transactions in flight.
REQ-036 Bench SHALL cover: LATENCY = 4, reset pulsed 2 cycles after a write accept -> no data_ok, target word unchanged, addr_ok = 1 the cycle after reset deasserts.
REQ-037 Bench SHALL cover: read of addr 0x8000_0010 with ADDR_W = 10 -> same data as addr 0x10 (high bits ignored).
